// File: rtl/spi_boot_loader_if.sv
// ---------------------------------------------------------------------------
// spi_boot_loader_if
//
// Bundles the image-source handshake and the SPI master pins of the boot
// loader. Signal names keep the loader's point of view (_o = driven by the
// loader, _i = driven by the image source / environment).
//
// Handshake (image port): img_req_o is a request that stays high until the
// source answers with img_valid_i; a word is transferred on every clock edge
// where img_req_o and img_valid_i are both high. img_valid_i while
// img_req_o is low carries no meaning and is ignored.
//
// Signals:
//   img_req_o    loader -> source   word request
//   img_idx_o    loader -> source   index of the requested word
//   img_data_i   source -> loader   image word
//   img_valid_i  source -> loader   img_data_i valid
//   spi_sclk_o   loader -> slave    SPI clock, mode 0 (idle low)
//   spi_cs_o     loader -> slave    chip select, active low
//   spi_sdo_o    loader -> slave    data lanes, lane 0 in single mode
// ---------------------------------------------------------------------------
interface spi_boot_loader_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              img_req_o;
    logic [IDX_W-1:0]  img_idx_o;
    logic [DATA_W-1:0] img_data_i;
    logic              img_valid_i;
    logic              spi_sclk_o;
    logic              spi_cs_o;
    logic [3:0]        spi_sdo_o;

    // Boot loader side.
    modport master (
        output img_req_o,
        output img_idx_o,
        input  img_data_i,
        input  img_valid_i,
        output spi_sclk_o,
        output spi_cs_o,
        output spi_sdo_o
    );

    // Image source / SPI slave side.
    modport slave (
        input  img_req_o,
        input  img_idx_o,
        output img_data_i,
        output img_valid_i,
        input  spi_sclk_o,
        input  spi_cs_o,
        input  spi_sdo_o
    );
endinterface

// File: rtl/spi_boot_loader.sv
// ---------------------------------------------------------------------------
// spi_boot_loader
//
// SPI-master boot loader. On start it fetches image words one at a time,
// sends each as a write frame {WR_CMD, BASE_ADDR + 4*i, word} to the core's
// SPI slave, and stops after the sentinel word (which is still sent) or after
// MAX_WORDS words. It then raises fetch_enable_o, one cycle later
// en_ifetch_o, keeps both high for RUN_CYCLES cycles (forever when 0), drops
// both together and flags done_o.
//
// Ports:
//   clk_i           system clock
//   rst_i           asynchronous active-high reset
//   start_i         begin a boot (ignored while busy_o)
//   quad_i          sampled at start: 1 = addr/data on 4 lanes
//   bus             image handshake + SPI pins (master modport)
//   fetch_enable_o  core fetch enable
//   en_ifetch_o     core instruction-fetch enable
//   busy_o          boot in progress
//   done_o          sticky: end of run window reached; cleared by start
//   words_sent_o    number of completed SPI transactions
//   dbg_state_o     current FSM state encoding (debug)
//
// Frame timing: CS is low for CLK_DIV setup cycles, then each SCLK period is
// 2*CLK_DIV cycles (data changes while SCLK is low), then CLK_DIV hold
// cycles, i.e. 2*CLK_DIV*(nsclk+1) cycles in total.
// ---------------------------------------------------------------------------
module spi_boot_loader #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter logic [7:0]        WR_CMD     = 8'h02,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h80,
    parameter int                MAX_WORDS  = 32,
    parameter logic [DATA_W-1:0] STOP_WORD  = 32'h00000fff,
    parameter int                CLK_DIV    = 4,
    parameter int                GAP_CYCLES = 20,
    parameter int                RUN_CYCLES = 10
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           quad_i,
    spi_boot_loader_if.master              bus,
    output logic                           fetch_enable_o,
    output logic                           en_ifetch_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic [$clog2(MAX_WORDS+1)-1:0] words_sent_o,
    output logic [3:0]                     dbg_state_o
);

    localparam int IDX_W   = $clog2(MAX_WORDS);
    localparam int WS_W    = $clog2(MAX_WORDS + 1);
    localparam int FW      = 8 + ADDR_W + DATA_W;        // full frame width
    localparam int NSCLK_S = FW;                         // single-lane SCLKs
    localparam int NSCLK_Q = 8 + (ADDR_W + DATA_W) / 4;  // quad-lane SCLKs
    localparam int BCW     = $clog2(FW + 1);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [31:0] GAP_LIM  = 32'(GAP_CYCLES);
    localparam logic [31:0] RUN_LIM  = 32'(RUN_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_CS_SETUP = 4'd2,
        S_SHIFT    = 4'd3,
        S_CS_HOLD  = 4'd4,
        S_GAP      = 4'd5,
        S_FE       = 4'd6,
        S_IF       = 4'd7,
        S_RUN      = 4'd8,
        S_DONE     = 4'd9
    } state_t;

    state_t            state_q, state_d;
    logic              arm_q;
    logic              quad_q, quad_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              stop_q, stop_d;
    logic              sclk_q, sclk_d;
    logic [15:0]       div_q, div_d;
    logic [BCW-1:0]    bit_q, bit_d;
    logic [31:0]       cnt_q, cnt_d;   // shared by GAP and RUN
    logic [WS_W-1:0]   sent_q, sent_d;
    logic              done_q, done_d;

    logic [BCW-1:0]    nsclk;
    logic              single_lane;
    logic              shifting;

    // Total SCLKs of the current frame and whether the current bit travels on
    // lane 0 only (always for the command byte).
    assign nsclk       = quad_q ? BCW'(NSCLK_Q) : BCW'(NSCLK_S);
    assign single_lane = (bit_q < BCW'(8)) || !quad_q;
    assign shifting    = (state_q == S_CS_SETUP) || (state_q == S_SHIFT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            arm_q   <= 1'b0;
            quad_q  <= 1'b0;
            idx_q   <= '0;
            frame_q <= '0;
            stop_q  <= 1'b0;
            sclk_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            sent_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Not armed on the first edge after reset release, so a start
            // coinciding with that release is dropped.
            arm_q   <= 1'b1;
            quad_q  <= quad_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            stop_q  <= stop_d;
            sclk_q  <= sclk_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            sent_q  <= sent_d;
            done_q  <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        quad_d  = quad_q;
        idx_d   = idx_q;
        frame_d = frame_q;
        stop_d  = stop_q;
        sclk_d  = sclk_q;
        div_d   = div_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        sent_d  = sent_q;
        done_d  = done_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE lasts one cycle; a start seen there is honoured too
                // because busy_o is already low.
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start_i && arm_q) begin
                    state_d = S_FETCH;
                    quad_d  = quad_i;
                    idx_d   = '0;
                    sent_d  = '0;
                    done_d  = 1'b0;
                end
            end

            S_FETCH: begin
                if (bus.img_valid_i) begin
                    frame_d = {WR_CMD, BASE_ADDR + (ADDR_W'(idx_q) << 2), bus.img_data_i};
                    stop_d  = (bus.img_data_i == STOP_WORD);
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = S_CS_SETUP;
                end
            end

            S_CS_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end

            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge: advance to the next bit / nibble.
                        sclk_d  = 1'b0;
                        frame_d = single_lane ? (frame_q << 1) : (frame_q << 4);
                        bit_d   = bit_q + BCW'(1);
                        if (bit_q == nsclk - BCW'(1)) state_d = S_CS_HOLD;
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end

            S_CS_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    cnt_d   = '0;
                    sent_d  = sent_q + WS_W'(1);
                    state_d = S_GAP;
                end else begin
                    div_d = div_q + 16'd1;
                end
            end

            S_GAP: begin
                if (cnt_q + 32'd1 >= GAP_LIM) begin
                    cnt_d = '0;
                    if (stop_q || (sent_q == WS_W'(MAX_WORDS))) begin
                        state_d = S_FE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            S_FE: state_d = S_IF;

            // The IF cycle is the first cycle of the run window.
            S_IF: begin
                cnt_d = 32'd1;
                if (RUN_CYCLES == 1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if ((RUN_CYCLES != 0) && (cnt_q + 32'd1 >= RUN_LIM)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (RUN_CYCLES != 0) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registers so reset takes effect immediately)
    // ------------------------------------------------------------------
    always_comb begin
        bus.spi_sdo_o = 4'b0000;
        if (shifting) begin
            if (single_lane) bus.spi_sdo_o = {3'b000, frame_q[FW-1]};
            else             bus.spi_sdo_o = frame_q[FW-1 -: 4];
        end
    end

    assign bus.spi_cs_o   = !(shifting || (state_q == S_CS_HOLD));
    assign bus.spi_sclk_o = sclk_q;
    assign bus.img_req_o  = (state_q == S_FETCH);
    assign bus.img_idx_o  = idx_q;

    assign fetch_enable_o = (state_q == S_FE) || (state_q == S_IF) || (state_q == S_RUN);
    assign en_ifetch_o    = (state_q == S_IF) || (state_q == S_RUN);
    assign busy_o         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o         = done_q;
    assign words_sent_o   = sent_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_spi_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_spi_boot_loader
//
// dut1: default parameters, fed by an image responder and watched by an SPI
// slave monitor that compares every frame against the expected queue.
// dut2: RUN_CYCLES=0 (fast SPI timing) to show the run window never closes.
// ---------------------------------------------------------------------------
module tb_spi_boot_loader;

    localparam logic [31:0] STOP = 32'h00000fff;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT wiring ----------------
    logic       start1, quad1, start2, quad2;
    logic       fe1, ife1, busy1, done1, fe2, ife2, busy2, done2;
    logic [5:0] ws1, ws2;
    logic [3:0] st1, st2;

    spi_boot_loader_if #(.DATA_W(32), .IDX_W(5)) bus1 ();
    spi_boot_loader_if #(.DATA_W(32), .IDX_W(5)) bus2 ();

    spi_boot_loader dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .quad_i(quad1), .bus(bus1),
        .fetch_enable_o(fe1), .en_ifetch_o(ife1), .busy_o(busy1), .done_o(done1),
        .words_sent_o(ws1), .dbg_state_o(st1)
    );

    spi_boot_loader #(.CLK_DIV(1), .GAP_CYCLES(2), .RUN_CYCLES(0)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .quad_i(quad2), .bus(bus2),
        .fetch_enable_o(fe2), .en_ifetch_o(ife2), .busy_o(busy2), .done_o(done2),
        .words_sent_o(ws2), .dbg_state_o(st2)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [71:0] exp_q[$];

    logic [31:0] img_mem[32];
    int          lat[32];
    int          wait_cnt;

    bit          mon_quad;
    bit          in_frame;
    bit          mon_prev_sclk;
    bit          mon_lane_err;
    int          mon_nsclk;
    int          mon_cs_low;
    int          mon_frames = 0;
    int          exp_sclk;
    logic [71:0] mon_frame;
    logic [71:0] mon_exp;
    logic [31:0] mon_last_addr;

    // ---------------- image responder (dut1) ----------------
    // Answers a request after lat[idx] extra cycles and records the frame the
    // slave must see for that word.
    initial begin
        wait_cnt = 0;
        bus1.img_valid_i = 1'b0;
        bus1.img_data_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !bus1.img_req_o) begin
                bus1.img_valid_i = 1'b0;
                wait_cnt = 0;
            end else if (!bus1.img_valid_i) begin
                if (wait_cnt < lat[bus1.img_idx_o]) begin
                    wait_cnt++;
                end else begin
                    bus1.img_data_i  = img_mem[bus1.img_idx_o];
                    bus1.img_valid_i = 1'b1;
                    exp_q.push_back({8'h02, 32'h80 + 32'(bus1.img_idx_o) * 32'd4,
                                     img_mem[bus1.img_idx_o]});
                end
            end
        end
    end

    // ---------------- SPI slave monitor (dut1) ----------------
    initial begin
        in_frame = 0;
        mon_prev_sclk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0;
                mon_prev_sclk = 0;
                mon_nsclk = 0;
            end else begin
                if (!bus1.spi_cs_o) begin
                    if (!in_frame) begin
                        in_frame = 1;
                        mon_cs_low = 0;
                        mon_nsclk = 0;
                        mon_frame = '0;
                        mon_lane_err = 0;
                    end
                    mon_cs_low++;
                    if (bus1.spi_sclk_o && !mon_prev_sclk) begin
                        if (mon_nsclk < 8 || !mon_quad) begin
                            mon_frame = {mon_frame[70:0], bus1.spi_sdo_o[0]};
                            if (bus1.spi_sdo_o[3:1] != 3'b000) mon_lane_err = 1;
                        end else begin
                            mon_frame = {mon_frame[67:0], bus1.spi_sdo_o};
                        end
                        mon_nsclk++;
                    end
                end else if (in_frame) begin
                    in_frame = 0;
                    mon_frames++;
                    exp_sclk = mon_quad ? 24 : 72;
                    checks++;
                    if (mon_nsclk != exp_sclk) begin
                        failures++;
                        $display("FAIL frame_sclks: got %0d expected %0d", mon_nsclk, exp_sclk);
                    end
                    checks++;
                    if (mon_cs_low != 2 * 4 * (exp_sclk + 1)) begin
                        failures++;
                        $display("FAIL frame_cs_low: got %0d expected %0d", mon_cs_low, 2 * 4 * (exp_sclk + 1));
                    end
                    checks++;
                    if (mon_lane_err) begin
                        failures++;
                        $display("FAIL unused_lanes: got nonzero expected 0");
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL frame_unexpected: got %h expected none", mon_frame);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        mon_last_addr = mon_frame[63:32];
                        if (mon_frame !== mon_exp) begin
                            failures++;
                            $display("FAIL frame_content: got %h expected %h", mon_frame, mon_exp);
                        end
                    end
                end
                mon_prev_sclk = bus1.spi_sclk_o;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_boot1(input bit q);
        @(negedge clk);
        quad1 = q;
        mon_quad = q;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic wait_done1(input int budget, output bit ok);
        int n;
        n = 0;
        while (!(done1 && !busy1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        ok = done1 && !busy1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus1.spi_cs_o !== 1'b1)   begin failures++; $display("FAIL rst_cs: got %b expected 1", bus1.spi_cs_o); end
        checks++; if (bus1.spi_sclk_o !== 1'b0) begin failures++; $display("FAIL rst_sclk: got %b expected 0", bus1.spi_sclk_o); end
        checks++; if (bus1.spi_sdo_o !== 4'h0)  begin failures++; $display("FAIL rst_sdo: got %h expected 0", bus1.spi_sdo_o); end
        checks++; if (bus1.img_req_o !== 1'b0)  begin failures++; $display("FAIL rst_req: got %b expected 0", bus1.img_req_o); end
        checks++; if (bus1.img_idx_o !== 5'd0)  begin failures++; $display("FAIL rst_idx: got %0d expected 0", bus1.img_idx_o); end
        checks++; if ({fe1, ife1} !== 2'b00)    begin failures++; $display("FAIL rst_enables: got %b expected 00", {fe1, ife1}); end
        checks++; if ({busy1, done1} !== 2'b00) begin failures++; $display("FAIL rst_busy_done: got %b expected 00", {busy1, done1}); end
        checks++; if (ws1 !== 6'd0)             begin failures++; $display("FAIL rst_words: got %0d expected 0", ws1); end
        // start coincident with reset release is dropped
        @(negedge clk);
        rst = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy1 !== 1'b0 || bus1.img_req_o !== 1'b0) begin failures++; $display("FAIL start_at_release: got busy=%b req=%b expected 0 0", busy1, bus1.img_req_o); end
    endtask

    task automatic test_single();
        int n;
        int f0;
        bit ok;
        img_mem[0] = 32'h11; img_mem[1] = 32'h22; img_mem[2] = STOP;
        f0 = mon_frames;
        start_boot1(1'b0);
        n = 0;
        while (!fe1 && n < 6000) begin @(negedge clk); n++; end
        checks++; if (!fe1) begin failures++; $display("FAIL single_fe_timeout: got fe=0 expected 1"); end
        checks++; if (ife1 !== 1'b0) begin failures++; $display("FAIL single_ife_early: got %b expected 0", ife1); end
        @(negedge clk);
        checks++; if ({fe1, ife1} !== 2'b11) begin failures++; $display("FAIL single_ife_rise: got %b expected 11", {fe1, ife1}); end
        n = 0;
        while (fe1 && ife1 && n < 100) begin n++; @(negedge clk); end
        checks++; if (n != 10) begin failures++; $display("FAIL single_run_len: got %0d expected 10", n); end
        checks++; if ({fe1, ife1} !== 2'b00) begin failures++; $display("FAIL single_drop: got %b expected 00", {fe1, ife1}); end
        checks++; if ({done1, busy1} !== 2'b10) begin failures++; $display("FAIL single_done_busy: got %b expected 10", {done1, busy1}); end
        checks++; if (ws1 !== 6'd3) begin failures++; $display("FAIL single_words: got %0d expected 3", ws1); end
        checks++; if (mon_frames - f0 != 3 || exp_q.size() != 0) begin failures++; $display("FAIL single_frames: got %0d left %0d expected 3 left 0", mon_frames - f0, exp_q.size()); end
        wait_done1(10, ok);
    endtask

    task automatic test_quad();
        int f0;
        bit ok;
        img_mem[0] = 32'hA5A5_0FF0; img_mem[1] = STOP;
        f0 = mon_frames;
        start_boot1(1'b1);
        wait_done1(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL quad_timeout: got done=%b expected 1", done1); end
        checks++; if (ws1 !== 6'd2) begin failures++; $display("FAIL quad_words: got %0d expected 2", ws1); end
        checks++; if (mon_frames - f0 != 2 || exp_q.size() != 0) begin failures++; $display("FAIL quad_frames: got %0d left %0d expected 2 left 0", mon_frames - f0, exp_q.size()); end
    endtask

    task automatic test_latency();
        int n;
        int bad;
        bit ok;
        img_mem[0] = 32'h1234_5678; img_mem[1] = 32'hCAFE_F00D; img_mem[2] = STOP;
        lat[1] = 6;   // request for word 1 stays up for 7 cycles
        start_boot1(1'b1);
        n = 0;
        while (!(bus1.img_req_o && bus1.img_idx_o == 5'd1) && n < 2000) begin @(negedge clk); n++; end
        checks++; if (!bus1.img_req_o) begin failures++; $display("FAIL lat_req_timeout: got req=0 expected 1"); end
        n = 0;
        bad = 0;
        while (bus1.img_req_o && n < 50) begin
            if (bus1.spi_sclk_o !== 1'b0 || bus1.spi_cs_o !== 1'b1) bad++;
            n++;
            @(negedge clk);
        end
        checks++; if (n != 7) begin failures++; $display("FAIL lat_req_len: got %0d expected 7", n); end
        checks++; if (bad != 0) begin failures++; $display("FAIL lat_idle: got %0d busy cycles expected 0", bad); end
        wait_done1(3000, ok);
        checks++; if (!ok || ws1 !== 6'd3) begin failures++; $display("FAIL lat_words: got %0d done=%b expected 3 done=1", ws1, done1); end
        lat[1] = 0;
    endtask

    task automatic test_no_sentinel();
        int f0;
        bit ok;
        for (int i = 0; i < 32; i++) begin
            img_mem[i] = $urandom;
            if (img_mem[i] == STOP) img_mem[i] = 32'h1;
            lat[i] = $urandom_range(0, 3);
        end
        f0 = mon_frames;
        start_boot1(1'b1);
        wait_done1(12000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL nosent_timeout: got done=%b expected 1", done1); end
        checks++; if (ws1 !== 6'd32) begin failures++; $display("FAIL nosent_words: got %0d expected 32", ws1); end
        checks++; if (mon_frames - f0 != 32 || exp_q.size() != 0) begin failures++; $display("FAIL nosent_frames: got %0d left %0d expected 32 left 0", mon_frames - f0, exp_q.size()); end
        checks++; if (mon_last_addr !== 32'hFC) begin failures++; $display("FAIL nosent_last_addr: got %h expected fc", mon_last_addr); end
        for (int i = 0; i < 32; i++) lat[i] = 0;
    endtask

    task automatic test_reset_mid();
        int n;
        int f0;
        bit ok;
        img_mem[0] = 32'h11; img_mem[1] = 32'h22; img_mem[2] = STOP;
        start_boot1(1'b0);
        n = 0;
        while (!(in_frame && mon_nsclk == 40) && n < 2000) begin @(negedge clk); n++; end
        checks++; if (mon_nsclk != 40) begin failures++; $display("FAIL rmid_reach: got %0d sclks expected 40", mon_nsclk); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({bus1.spi_cs_o, bus1.spi_sclk_o} !== 2'b10) begin failures++; $display("FAIL rmid_cs_sclk: got %b expected 10", {bus1.spi_cs_o, bus1.spi_sclk_o}); end
        checks++; if (bus1.spi_sdo_o !== 4'h0) begin failures++; $display("FAIL rmid_sdo: got %h expected 0", bus1.spi_sdo_o); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", busy1); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        img_mem[0] = 32'h0BAD_F00D; img_mem[1] = STOP;
        f0 = mon_frames;
        start_boot1(1'b1);
        n = 0;
        while (!bus1.img_req_o && n < 100) begin @(negedge clk); n++; end
        checks++; if (!bus1.img_req_o || bus1.img_idx_o !== 5'd0) begin failures++; $display("FAIL rmid_restart_idx: got req=%b idx=%0d expected 1 0", bus1.img_req_o, bus1.img_idx_o); end
        wait_done1(3000, ok);
        checks++; if (!ok || ws1 !== 6'd2 || mon_frames - f0 != 2) begin failures++; $display("FAIL rmid_restart: got words=%0d frames=%0d expected 2 2", ws1, mon_frames - f0); end
    endtask

    task automatic test_gap_start();
        int n;
        int f0;
        bit ok;
        img_mem[0] = 32'h55; img_mem[1] = 32'h66; img_mem[2] = STOP;
        f0 = mon_frames;
        start_boot1(1'b1);
        n = 0;
        while (st1 != 4'd5 && n < 1000) begin @(negedge clk); n++; end
        checks++; if (st1 !== 4'd5) begin failures++; $display("FAIL gap_reach: got state %0d expected 5", st1); end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checks++; if (busy1 !== 1'b1 || st1 !== 4'd5) begin failures++; $display("FAIL gap_start_busy: got busy=%b state=%0d expected 1 5", busy1, st1); end
        n = 0;
        while (!bus1.img_req_o && n < 200) begin @(negedge clk); n++; end
        checks++; if (bus1.img_idx_o !== 5'd1) begin failures++; $display("FAIL gap_next_idx: got %0d expected 1", bus1.img_idx_o); end
        wait_done1(3000, ok);
        checks++; if (!ok || ws1 !== 6'd3 || mon_frames - f0 != 3 || exp_q.size() != 0) begin failures++; $display("FAIL gap_sequence: got words=%0d frames=%0d expected 3 3", ws1, mon_frames - f0); end
    endtask

    task automatic test_run_hold();
        int n;
        int bad;
        @(negedge clk);
        quad2 = 1'b0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (!bus2.img_req_o && n < 100) begin @(negedge clk); n++; end
        bus2.img_data_i = STOP;
        bus2.img_valid_i = 1'b1;
        @(negedge clk);
        bus2.img_valid_i = 1'b0;
        n = 0;
        while (!fe2 && n < 500) begin @(negedge clk); n++; end
        checks++; if (!fe2) begin failures++; $display("FAIL hold_fe_timeout: got fe=0 expected 1"); end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (!(fe2 && ife2 && busy2 && !done2)) bad++;
            @(negedge clk);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL hold_window: got %0d bad cycles expected 0", bad); end
        checks++; if (done2 !== 1'b0 || ws2 !== 6'd1) begin failures++; $display("FAIL hold_done: got done=%b words=%0d expected 0 1", done2, ws2); end
    endtask

    // ---------------- sequence ----------------
    initial begin
        start1 = 0; quad1 = 0; start2 = 0; quad2 = 0; mon_quad = 0;
        bus2.img_valid_i = 1'b0;
        bus2.img_data_i = '0;
        mon_last_addr = '0;
        for (int i = 0; i < 32; i++) begin
            img_mem[i] = '0;
            lat[i] = 0;
        end
        test_reset();
        test_single();
        test_quad();
        test_latency();
        test_no_sentinel();
        test_reset_mid();
        test_gap_start();
        test_run_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
